// File: rtl/wallace_mul_arbiter.sv
// Round-robin arbiter sharing one combinational 8x8 Wallace-tree multiplier
// among up to four requesters.
//
// wallace_csa        : word-wide 3:2 carry-save compressor (one tree level)
//   i_x/i_y/i_z in W  : three addend rows
//   o_sum/o_cry out W : sum row and left-shifted carry row
//
// wallace_multiplier : unsigned 8x8 -> 16 combinational multiplier
//   a, b in 8         : operands
//   ans out 16        : product
//
// wallace_mul_arbiter: top level
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready [NREQ]   : per-requester request handshake
//   in_a/in_b [8*NREQ]         : packed operand pairs, requester i at [8i+7:8i]
//   out_valid/out_ready        : result handshake
//   out_prod [16], out_id [2]  : registered product and owning requester
//   done_cnt [16]              : completed result handshakes, wraps

module wallace_csa #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_z,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_cry
);

    logic [W-1:0] w_maj;

    assign o_sum = i_x ^ i_y ^ i_z;
    assign w_maj = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);

    // A carry out of the top column would be bit W; the product always fits
    // in W bits, so working modulo 2^W is exact.
    assign o_cry = w_maj << 1;

endmodule

module wallace_multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] ans
);

    logic [15:0] w_pp [8];

    // Level 1: 8 rows -> 6 rows
    logic [15:0] w_s1a;
    logic [15:0] w_c1a;
    logic [15:0] w_s1b;
    logic [15:0] w_c1b;

    // Level 2: 6 rows -> 4 rows
    logic [15:0] w_s2a;
    logic [15:0] w_c2a;
    logic [15:0] w_s2b;
    logic [15:0] w_c2b;

    // Level 3: 4 rows -> 3 rows
    logic [15:0] w_s3;
    logic [15:0] w_c3;

    // Level 4: 3 rows -> 2 rows
    logic [15:0] w_s4;
    logic [15:0] w_c4;

    // Row i is A gated by bit i of B, aligned to column i.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_pp[i] = 16'(a & {8{b[i]}}) << i;
        end
    end

    wallace_csa #(.W(16)) u_l1a (
        .i_x   (w_pp[0]),
        .i_y   (w_pp[1]),
        .i_z   (w_pp[2]),
        .o_sum (w_s1a),
        .o_cry (w_c1a)
    );

    wallace_csa #(.W(16)) u_l1b (
        .i_x   (w_pp[3]),
        .i_y   (w_pp[4]),
        .i_z   (w_pp[5]),
        .o_sum (w_s1b),
        .o_cry (w_c1b)
    );

    wallace_csa #(.W(16)) u_l2a (
        .i_x   (w_s1a),
        .i_y   (w_c1a),
        .i_z   (w_s1b),
        .o_sum (w_s2a),
        .o_cry (w_c2a)
    );

    wallace_csa #(.W(16)) u_l2b (
        .i_x   (w_c1b),
        .i_y   (w_pp[6]),
        .i_z   (w_pp[7]),
        .o_sum (w_s2b),
        .o_cry (w_c2b)
    );

    wallace_csa #(.W(16)) u_l3 (
        .i_x   (w_s2a),
        .i_y   (w_c2a),
        .i_z   (w_s2b),
        .o_sum (w_s3),
        .o_cry (w_c3)
    );

    wallace_csa #(.W(16)) u_l4 (
        .i_x   (w_s3),
        .i_y   (w_c3),
        .i_z   (w_c2b),
        .o_sum (w_s4),
        .o_cry (w_c4)
    );

    // Final carry-propagate adder.
    assign ans = w_s4 + w_c4;

endmodule

module wallace_mul_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   in_valid,
    output logic [NREQ-1:0]   in_ready,
    input  logic [8*NREQ-1:0] in_a,
    input  logic [8*NREQ-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_prod,
    output logic [1:0]        out_id,
    output logic [15:0]       done_cnt
);

    // One-hot state so out_valid is a flop output, not decode logic.
    localparam int I_IDLE = 0;
    localparam int I_CALC = 1;
    localparam int I_DONE = 2;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_CALC = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;

    logic [1:0]  r_rr_ptr;
    logic [7:0]  r_op_a;
    logic [7:0]  r_op_b;
    logic [1:0]  r_op_id;
    logic [15:0] r_prod;
    logic [1:0]  r_id;
    logic [15:0] r_done_cnt;

    // Requester-side signals widened to the 4-slot maximum so a 2-bit
    // index always selects in range; missing slots read as zero.
    logic [3:0]  w_valid_pad;
    logic [31:0] w_a_pad;
    logic [31:0] w_b_pad;
    logic [3:0]  w_ready_pad;

    logic [2:0]  w_probe;
    logic        w_gnt_vld;
    logic [1:0]  w_gnt_idx;
    logic        w_accept;
    logic        w_out_hs;
    logic [15:0] w_ans;

    assign w_valid_pad = 4'(in_valid);
    assign w_a_pad     = 32'(in_a);
    assign w_b_pad     = 32'(in_b);

    // Round-robin search. Offsets are scanned from the far end so the
    // last hit, which wins, is the one nearest to r_rr_ptr.
    always_comb begin
        w_probe   = '0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_probe = {1'b0, r_rr_ptr} + 3'(k);
            if (w_probe >= 3'(NREQ)) begin
                w_probe = w_probe - 3'(NREQ);
            end
            if (w_valid_pad[w_probe[1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_probe[1:0];
            end
        end
    end

    assign w_accept = r_state[I_IDLE] & w_gnt_vld;
    assign w_out_hs = r_state[I_DONE] & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (1'b1)
            r_state[I_IDLE]: begin
                if (w_gnt_vld) begin
                    w_state_nxt = S_CALC;
                end
            end
            r_state[I_CALC]: begin
                w_state_nxt = S_DONE;
            end
            r_state[I_DONE]: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic. in_ready depends only on state, pointer and in_valid.
    always_comb begin
        w_ready_pad = '0;
        if (w_accept) begin
            w_ready_pad[w_gnt_idx] = 1'b1;
        end
    end

    assign in_ready  = w_ready_pad[NREQ-1:0];
    assign out_valid = r_state[I_DONE];
    assign out_prod  = r_prod;
    assign out_id    = r_id;
    assign done_cnt  = r_done_cnt;

    // Operand capture and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_id  <= '0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_op_a  <= w_a_pad[{w_gnt_idx, 3'b000} +: 8];
            r_op_b  <= w_b_pad[{w_gnt_idx, 3'b000} +: 8];
            r_op_id <= w_gnt_idx;
            if (w_gnt_idx == 2'(NREQ - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_gnt_idx + 2'd1;
            end
        end
    end

    // The multiplier sees only captured operands, never live inputs.
    wallace_multiplier u_mul (
        .a   (r_op_a),
        .b   (r_op_b),
        .ans (w_ans)
    );

    // Result register, loaded once in CALC and held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_id   <= '0;
        end else if (r_state[I_CALC]) begin
            r_prod <= w_ans;
            r_id   <= r_op_id;
        end
    end

    // Completion counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
        end else if (w_out_hs) begin
            r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

endmodule
